mainfsm: RTL and testbench
==========================

# mainfsm

- Multicycle RV32I controller state machine.
- Produces the per-cycle datapath enables and mux selects for the multicycle processor.
- Drives the 2-bit ALUOp consumed by aludec; the other end of the ALUOp interface.
- Sits beside aludec inside the controller and sequences each instruction through Fetch/Decode/Execute/Writeback (lw, sw, R-type, I-type ALU, jal, beq).

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces Fetch immediately.
- op  in  7  opcode from instruction register, instr[6:0].
- Zero  in  1  ALU zero flag.
- PCWrite  out  1  PCUpdate | (Branch & Zero).
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- IRWrite  out  1  instruction register load.
- MemWrite  out  1  data memory write enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result mux select.
- ALUSrcA  out  2  ALU A select.
- ALUSrcB  out  2  ALU B select.
- ALUOp  out  2  to aludec.
- Illegal  out  1  illegal-opcode flag; see Configuration.

## Operation
- Moore FSM, 11 base states; every output not listed for a state is 0.
- Outputs are pure functions of state; the only exception is PCWrite, which is combinational in Zero.
- Fetch: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state: Decode.
- Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
  - 0000011 or 0100011 → MemAdr.
  - 0110011 → ExecuteR.
  - 0010011 → ExecuteI.
  - 1101111 → JAL.
  - 1100011 → BEQ.
  - Any other op → illegal handling (Configuration).
- MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: op=0000011 → MemRead, otherwise MemWrite.
- MemRead: AdrSrc=1, ResultSrc=00. Next: MemWB.
- MemWB: ResultSrc=01, RegWrite=1. Next: Fetch.
- MemWrite: AdrSrc=1, MemWrite=1. Next: Fetch.
- ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: Fetch.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: Fetch.
  - PCWrite=Zero in this state.
- PCUpdate and Branch are internal only; they never appear as ports.

## Timing
- Reset value: state=Fetch, so outputs are IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, all others 0, Illegal=0.
- Reset asserted mid-instruction aborts it asynchronously; an in-flight MemWrite or RegWrite deasserts in the same cycle.
- First Fetch after reset release lasts exactly one cycle.
- op is sampled only on the Decode→ and MemAdr→ transitions; op changes in other states are ignored.
- Instruction latency in cycles, counted from Fetch: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- Zero affects only PCWrite, only in BEQ, with zero-cycle (combinational) delay.
- At most one of IRWrite, MemWrite, RegWrite is high in any cycle.

## Configuration
- MAINFSM_ILLEGAL_EN defined:
  - An unrecognised op in Decode enters a 12th state, Halt.
  - Halt: all outputs 0 except Illegal=1.
  - Halt is left only by reset.
- MAINFSM_ILLEGAL_EN undefined:
  - An unrecognised op in Decode returns to Fetch; the instruction is a 2-cycle no-op.
  - Illegal is tied to 0.
  - Halt does not exist.

## Test plan
- Reset mid-ExecuteR → Fetch outputs in the same cycle; after release, sequence Fetch→Decode.
- op=0000011 → states Fetch, Decode, MemAdr, MemRead, MemWB, then Fetch:
  - ALUOp 00 throughout.
  - AdrSrc=1 in MemRead.
  - RegWrite=1 and ResultSrc=01 in MemWB only.
- op=0100011 → MemWrite=1 exactly in cycle 4; RegWrite never high.
- op=0110011 and op=0010011 → ALUOp=10 in cycle 3, with ALUSrcB 00 and 01 respectively; RegWrite=1 in cycle 4.
- op=1100011:
  - Zero=1 → PCWrite=1 in cycle 3, ALUOp=01.
  - Zero=0 → PCWrite=0 in cycle 3.
  - Toggling Zero in other states has no effect on PCWrite.
- op=1111111:
  - Macro on → Illegal=1 and all enables 0, held for 20 cycles until reset.
  - Macro off → back in Fetch after Decode, Illegal=0.

Source files
------------

// File: rtl/mainfsm_if.sv
// Controller bundle between mainfsm and the multicycle datapath: opcode/zero in,
// per-cycle enables and mux selects out.
interface mainfsm_if;
    logic [6:0] op;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       Illegal;

    modport master (
        output op, Zero,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal
    );
    modport slave (
        input  op, Zero,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal
    );
endinterface

// File: rtl/mainfsm.sv
// Multicycle RV32I main controller FSM (Moore; PCWrite is the only Zero-dependent output).
// Define MAINFSM_ILLEGAL_EN to trap unrecognised opcodes in a Halt state left only by reset.
module mainfsm (
    input  logic      clk,
    input  logic      reset,
    mainfsm_if.slave  bus
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;
`ifdef MAINFSM_ILLEGAL_EN
    localparam logic [3:0] S_HALT     = 4'd11;
`endif

    logic [3:0] state, state_nxt;
    logic       pc_update, branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_BEQ:       state_nxt = S_BEQ;
`ifdef MAINFSM_ILLEGAL_EN
                    default:      state_nxt = S_HALT;
`else
                    // unknown opcodes fall through as a two-cycle no-op
                    default:      state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: state_nxt = S_FETCH;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_BEQ:      state_nxt = S_FETCH;
`ifdef MAINFSM_ILLEGAL_EN
            S_HALT:     state_nxt = S_HALT;
`endif
            default:    state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 2'b00;
        bus.Illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                pc_update     = 1'b1;
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b10;
            end
            S_EXECI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 2'b10;
            end
            S_ALUWB:    bus.RegWrite = 1'b1;
            S_JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                pc_update   = 1'b1;
            end
            S_BEQ: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b01;
                branch      = 1'b1;
            end
`ifdef MAINFSM_ILLEGAL_EN
            S_HALT:     bus.Illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    // Zero reaches PCWrite combinationally so a taken beq updates PC in its only cycle
    assign bus.PCWrite = pc_update | (branch & bus.Zero);
endmodule

// File: tb/tb_mainfsm.sv
// Bench for mainfsm: spec vector table, abort-by-reset sequences, illegal-op handling
// and random instruction streams against an instruction-level reference model.
module tb_mainfsm;
    typedef struct packed {
        logic       pcw, adr, irw, memw, regw;
        logic [1:0] rsrc, srca, srcb, aluop;
        logic       ill;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic       zero;
        int         lat;
        out_t       exp3;
    } vec_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mainfsm_if bus();
    mainfsm dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b1101111: return K_JAL;
            7'b1100011: return K_BEQ;
            default:    return K_ILL;
        endcase
    endfunction

    // What the datapath must see in cycle 'step' (1 = Fetch) of an instruction of kind k
    function automatic out_t model(input int k, input int step, input logic z);
        out_t o = '0;
        if (step == 1) begin
            o.pcw = 1'b1; o.irw = 1'b1; o.srcb = 2'b10; o.rsrc = 2'b10;
        end else if (step == 2) begin
            o.srca = 2'b01; o.srcb = 2'b01;
        end else if (k == K_ILL) begin
            o.ill = 1'b1;
        end else if (step == 3) begin
            case (k)
                K_LW, K_SW: begin o.srca = 2'b10; o.srcb = 2'b01; end
                K_R:        begin o.srca = 2'b10; o.aluop = 2'b10; end
                K_I:        begin o.srca = 2'b10; o.srcb = 2'b01; o.aluop = 2'b10; end
                K_JAL:      begin o.srca = 2'b01; o.srcb = 2'b10; o.pcw = 1'b1; end
                default:    begin o.srca = 2'b10; o.aluop = 2'b01; o.pcw = z; end
            endcase
        end else if (step == 4) begin
            case (k)
                K_LW:    o.adr = 1'b1;
                K_SW:    begin o.adr = 1'b1; o.memw = 1'b1; end
                default: o.regw = 1'b1;
            endcase
        end else begin
            o.rsrc = 2'b01; o.regw = 1'b1;
        end
        return o;
    endfunction

    function automatic int lat_of(input int k);
        case (k)
            K_LW:    return 5;
            K_BEQ:   return 3;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.pcw = bus.PCWrite;   o.adr = bus.AdrSrc;    o.irw = bus.IRWrite;
        o.memw = bus.MemWrite; o.regw = bus.RegWrite; o.rsrc = bus.ResultSrc;
        o.srca = bus.ALUSrcA;  o.srcb = bus.ALUSrcB;  o.aluop = bus.ALUOp;
        o.ill = bus.Illegal;
        return o;
    endfunction

    task automatic check(input string nm, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (pcw adr irw memw regw rsrc srca srcb aluop ill)",
                     nm, act, exp);
        end
    endtask

    // Entered and left at posedge+1: drive, settle, compare, advance one clock
    task automatic cyc(input logic [6:0] o, input logic z, input out_t e, input string nm);
        bus.op = o; bus.Zero = z;
        #2;
        check(nm, dut_out(), e);
        @(posedge clk); #1;
    endtask

    // zmode 0/1 holds Zero, 2 randomises it; op is garbage wherever it must be ignored
    task automatic run_instr(input logic [6:0] op, input int zmode, input int n,
                             input bit chk3, input out_t exp3, input string nm);
        int k = kind_of(op);
        for (int s = 1; s <= n; s++) begin
            logic z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            logic [6:0] ov = (s == 2 || (s == 3 && (k == K_LW || k == K_SW))) ? op : 7'($urandom);
            bus.op = ov; bus.Zero = z;
            #2;
            check(nm, dut_out(), model(k, s, z));
            if (s == 3 && chk3) check({nm, "_c3"}, dut_out(), exp3);
            @(posedge clk); #1;
        end
    endtask

    // Run 'pre' cycles of op, then assert reset inside the next cycle
    task automatic abort_at(input logic [6:0] op, input int pre, input string nm);
        int k = kind_of(op);
        for (int s = 1; s <= pre; s++) cyc(op, 1'b0, model(k, s, 1'b0), nm);
        bus.op = 7'($urandom);
        #1;
        check({nm, "_pre"}, dut_out(), model(k, pre + 1, 1'b0));
        reset = 1'b1;
        #1;
        check({nm, "_async"}, dut_out(), model(K_LW, 1, 1'b0));
        @(posedge clk); #1;
        check({nm, "_held"}, dut_out(), model(K_LW, 1, 1'b0));
        reset = 1'b0;
    endtask

    vec_t vecs[$];
    out_t nil;

    initial begin
        nil = '0;
        reset = 1'b1; bus.op = 7'b0110011; bus.Zero = 1'b0;
        #1;
        check("reset_state", dut_out(),
              '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0});
        @(posedge clk); #1;
        reset = 1'b0;

        //                 op           z     lat  pcw adr irw mw rw rsrc   srca   srcb   aluop  ill
        vecs.push_back('{7'b0000011, 1'b0, 5, '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0}});
        vecs.push_back('{7'b0000011, 1'b1, 5, '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0}});
        vecs.push_back('{7'b0100011, 1'b1, 4, '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0}});
        vecs.push_back('{7'b0110011, 1'b0, 4, '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0}});
        vecs.push_back('{7'b0010011, 1'b1, 4, '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,1'b0}});
        vecs.push_back('{7'b1101111, 1'b0, 4, '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0}});
        vecs.push_back('{7'b1100011, 1'b1, 3, '{1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0}});
        vecs.push_back('{7'b1100011, 1'b0, 3, '{1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0}});
`ifndef MAINFSM_ILLEGAL_EN
        vecs.push_back('{7'b1111111, 1'b0, 2, nil});
`endif
        foreach (vecs[i])
            run_instr(vecs[i].op, int'(vecs[i].zero), vecs[i].lat, vecs[i].lat >= 3,
                      vecs[i].exp3, $sformatf("vec%0d", i));
        cyc(7'b0, 1'b0, model(K_LW, 1, 1'b0), "vec_tail_fetch");

        // cycle 1 above was Fetch; we are now in Decode, so rewind via reset
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;

        abort_at(7'b0110011, 2, "abort_execr");
        run_instr(7'b0110011, 2, 4, 1'b0, nil, "after_abort_r");
        abort_at(7'b0100011, 3, "abort_memwrite");
        abort_at(7'b0000011, 4, "abort_memwb");
        run_instr(7'b0000011, 2, 5, 1'b0, nil, "after_abort_lw");

        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            int pick = int'($urandom_range(0, 6));
            case (pick)
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                2: op = 7'b0110011;
                3: op = 7'b0010011;
                4: op = 7'b1101111;
                5: op = 7'b1100011;
                default: begin
                    op = 7'($urandom);
`ifdef MAINFSM_ILLEGAL_EN
                    if (kind_of(op) == K_ILL) op = 7'b1100011;
`endif
                end
            endcase
            run_instr(op, 2, lat_of(kind_of(op)), 1'b0, nil, "rand");
        end

`ifdef MAINFSM_ILLEGAL_EN
        run_instr(7'b1111111, 0, 2, 1'b0, nil, "ill_enter");
        for (int c = 0; c < 20; c++) cyc(7'($urandom), 1'($urandom), model(K_ILL, 3, 1'b0), "halt_hold");
        reset = 1'b1;
        #1;
        check("halt_reset", dut_out(), model(K_LW, 1, 1'b0));
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(7'b0010011, 2, 4, 1'b0, nil, "after_halt");
`else
        run_instr(7'b1111111, 1, 2, 1'b0, nil, "ill_nop");
        cyc(7'b0, 1'b0, model(K_LW, 1, 1'b0), "ill_back_fetch");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
